// File: rtl/connect_move_ctrl.sv
// Move controller for a column-drop board game: turns keyboard column presses
// into one-cycle red/black drop pulses, rejects full columns, and locks out at game end.
module connect_move_ctrl #(
    parameter int         NUM_COLS = 7,
    parameter int         NUM_ROWS = 6,
    parameter logic [7:0] KEY_BASE = 8'h1E
) (
    input  logic                frame_clk,
    input  logic                Reset_n,
    input  logic [7:0]          keycode,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                game_over,
    output logic [NUM_COLS-1:0] drop_red,
    output logic [NUM_COLS-1:0] drop_black,
    output logic                turn_red,
    output logic                invalid_move,
    output logic [5:0]          move_count,
    output logic                board_full
);

    localparam int                COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [5:0]        CAPACITY = 6'(NUM_COLS * NUM_ROWS);
    localparam logic [8:0]        KEY_LO   = {1'b0, KEY_BASE};
    localparam logic [8:0]        KEY_HI   = KEY_LO + 9'(NUM_COLS);
    localparam logic [NUM_COLS-1:0] COL0_HOT = NUM_COLS'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_REL,
        OVER
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;

    logic [NUM_COLS-1:0] drop_red_d, drop_black_d;
    logic                turn_red_d, invalid_move_d, board_full_d;
    logic [5:0]          move_count_d;

    // Key decode: 9-bit compare so KEY_BASE+NUM_COLS may exceed 8'hFF.
    logic [8:0]          key_ext;
    logic                key_in_range;
    logic [COL_W-1:0]    key_col;

    assign key_ext      = {1'b0, keycode};
    assign key_in_range = (key_ext >= KEY_LO) && (key_ext < KEY_HI);
    assign key_col      = COL_W'(key_ext - KEY_LO);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d        = state_q;
        col_d          = col_q;
        drop_red_d     = '0;
        drop_black_d   = '0;
        invalid_move_d = 1'b0;
        turn_red_d     = turn_red;
        move_count_d   = move_count;
        board_full_d   = board_full;

        case (state_q)
            IDLE: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (keycode != 8'h00) begin
                    if (!key_in_range) begin
                        state_d = WAIT_REL;
                    end else if (col_full[key_col]) begin
                        invalid_move_d = 1'b1;
                        state_d        = WAIT_REL;
                    end else begin
                        col_d   = key_col;
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (turn_red) begin
                    drop_red_d = COL0_HOT << col_q;
                end else begin
                    drop_black_d = COL0_HOT << col_q;
                end
                turn_red_d   = ~turn_red;
                move_count_d = (move_count == CAPACITY) ? move_count : move_count + 6'd1;
                board_full_d = (move_count_d == CAPACITY);
                state_d      = (board_full_d || game_over) ? OVER : WAIT_REL;
            end

            WAIT_REL: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (keycode == 8'h00) begin
                    state_d = IDLE;
                end
            end

            OVER: begin
                state_d = OVER;
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            drop_red     <= '0;
            drop_black   <= '0;
            invalid_move <= 1'b0;
            turn_red     <= 1'b1;
            move_count   <= '0;
            board_full   <= 1'b0;
        end else begin
            drop_red     <= drop_red_d;
            drop_black   <= drop_black_d;
            invalid_move <= invalid_move_d;
            turn_red     <= turn_red_d;
            move_count   <= move_count_d;
            board_full   <= board_full_d;
        end
    end

endmodule

// File: tb/tb_connect_move_ctrl.sv
// Self-checking bench for connect_move_ctrl: directed press table, corner-case
// sequences, and randomized presses against a press-level reference model.
module tb_connect_move_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b1;
    logic [7:0] keycode   = 8'h00;
    logic [6:0] col_full  = 7'h00;
    logic       game_over = 1'b0;
    logic [6:0] drop_red, drop_black;
    logic       turn_red, invalid_move, board_full;
    logic [5:0] move_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: whose turn, accepted moves, locked out.
    logic m_turn;
    int   m_count;
    logic m_over;

    typedef struct {
        logic [7:0] key0;
        logic [7:0] key1;
        int         hold;
        int         rel;
        logic [6:0] cf;
        logic [6:0] exp_red;
        logic [6:0] exp_black;
        int         exp_inv;
        logic       exp_turn;
        logic [5:0] exp_count;
    } vec_t;

    vec_t tbl[11];

    connect_move_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .col_full    (col_full),
        .game_over   (game_over),
        .drop_red    (drop_red),
        .drop_black  (drop_black),
        .turn_red    (turn_red),
        .invalid_move(invalid_move),
        .move_count  (move_count),
        .board_full  (board_full)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset_n   = 1'b0;
        keycode   = 8'h00;
        col_full  = 7'h00;
        game_over = 1'b0;
        repeat (2) @(posedge frame_clk);
        @(negedge frame_clk);
        Reset_n = 1'b1;
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    // One press window: key held for hold edges (possibly switching to key1
    // halfway), then released for rel edges. Drop pulse expected after edge 1.
    task automatic apply_press(input vec_t v);
        int inv_seen;
        inv_seen = 0;
        col_full = v.cf;
        for (int i = 0; i < v.hold + v.rel; i++) begin
            if (i >= v.hold) keycode = 8'h00;
            else if (i > 0 && i >= v.hold / 2 && v.key1 != 8'h00) keycode = v.key1;
            else keycode = v.key0;
            step();
            check($sformatf("drop_red edge%0d key %02h", i, v.key0), drop_red,
                  (i == 1) ? v.exp_red : 7'h00);
            check($sformatf("drop_black edge%0d key %02h", i, v.key0), drop_black,
                  (i == 1) ? v.exp_black : 7'h00);
            if (invalid_move) inv_seen++;
        end
        check($sformatf("invalid pulses key %02h", v.key0), inv_seen, v.exp_inv);
        check($sformatf("turn_red after key %02h", v.key0), turn_red, v.exp_turn);
        check($sformatf("move_count after key %02h", v.key0), move_count, v.exp_count);
        check($sformatf("board_full after key %02h", v.key0), board_full, v.exp_count == 6'd42);
        col_full = 7'h00;
    endtask

    // Press-level model: only the first code of a press matters.
    task automatic model_press(input logic [7:0] k0, input logic [6:0] cf,
                               output logic [6:0] er, output logic [6:0] eb, output int einv);
        er   = 7'h00;
        eb   = 7'h00;
        einv = 0;
        if (!m_over && k0 >= 8'h1E && k0 < 8'h1E + 7) begin
            int c;
            c = int'(k0) - 'h1E;
            if (cf[c]) begin
                einv = 1;
            end else begin
                if (m_turn) er = 7'(1 << c);
                else        eb = 7'(1 << c);
                m_turn = ~m_turn;
                m_count++;
                if (m_count == 42) m_over = 1'b1;
            end
        end
    endtask

    initial begin
        logic [7:0] oor[5];
        vec_t       v;
        logic [6:0] er, eb;
        int         einv, extra;

        oor = '{8'h1D, 8'h25, 8'h30, 8'hFF, 8'h01};

        //            key0   key1   h  r  cf         red        black      inv turn cnt
        tbl[0]  = '{8'h1E, 8'h00, 2, 2, 7'h00,      7'b0000001, 7'h00,      0, 1'b0, 6'd1};
        tbl[1]  = '{8'h1E, 8'h00, 1, 2, 7'h00,      7'h00,      7'b0000001, 0, 1'b1, 6'd2};
        tbl[2]  = '{8'h22, 8'h00, 5, 2, 7'h00,      7'b0010000, 7'h00,      0, 1'b0, 6'd3};
        tbl[3]  = '{8'h20, 8'h00, 2, 2, 7'b0000100, 7'h00,      7'h00,      1, 1'b0, 6'd3};
        tbl[4]  = '{8'h30, 8'h00, 2, 2, 7'h00,      7'h00,      7'h00,      0, 1'b0, 6'd3};
        tbl[5]  = '{8'h1D, 8'h00, 2, 2, 7'h00,      7'h00,      7'h00,      0, 1'b0, 6'd3};
        tbl[6]  = '{8'h25, 8'h00, 2, 2, 7'h00,      7'h00,      7'h00,      0, 1'b0, 6'd3};
        tbl[7]  = '{8'h24, 8'h00, 3, 2, 7'b0000100, 7'h00,      7'b1000000, 0, 1'b1, 6'd4};
        tbl[8]  = '{8'h1E, 8'h21, 4, 2, 7'h00,      7'b0000001, 7'h00,      0, 1'b0, 6'd5};
        tbl[9]  = '{8'h21, 8'h00, 2, 2, 7'b1111111, 7'h00,      7'h00,      1, 1'b0, 6'd5};
        tbl[10] = '{8'h23, 8'h00, 1, 3, 7'h00,      7'h00,      7'b0100000, 0, 1'b1, 6'd6};

        // Asynchronous reset values, before any clock edge.
        #1 Reset_n = 1'b0;
        #2;
        check("reset drop_red", drop_red, 7'h00);
        check("reset drop_black", drop_black, 7'h00);
        check("reset invalid_move", invalid_move, 1'b0);
        check("reset turn_red", turn_red, 1'b1);
        check("reset move_count", move_count, 6'd0);
        check("reset board_full", board_full, 1'b0);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 11; i++) apply_press(tbl[i]);

        // game_over together with a valid key in IDLE wins; lockout afterwards.
        keycode   = 8'h24;
        game_over = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("game_over drop_red edge%0d", i), drop_red, 7'h00);
            check($sformatf("game_over drop_black edge%0d", i), drop_black, 7'h00);
            check($sformatf("game_over invalid edge%0d", i), invalid_move, 1'b0);
        end
        game_over = 1'b0;
        keycode   = 8'h00;
        repeat (2) step();
        apply_press('{8'h1E, 8'h00, 2, 2, 7'h00, 7'h00, 7'h00, 0, 1'b1, 6'd6});
        apply_press('{8'h20, 8'h00, 2, 2, 7'b0000100, 7'h00, 7'h00, 0, 1'b1, 6'd6});

        // Reset during the drop pulse clears it at once; key held across reset is a new press.
        do_reset();
        keycode = 8'h22;
        step();
        check("pre-pulse drop_red", drop_red, 7'h00);
        step();
        check("pulse before reset", drop_red, 7'b0010000);
        Reset_n = 1'b0;
        #1;
        check("async reset drop_red", drop_red, 7'h00);
        check("async reset drop_black", drop_black, 7'h00);
        check("async reset move_count", move_count, 6'd0);
        check("async reset turn_red", turn_red, 1'b1);
        @(negedge frame_clk);
        Reset_n = 1'b1;
        apply_press('{8'h22, 8'h00, 2, 2, 7'h00, 7'b0010000, 7'h00, 0, 1'b0, 6'd1});

        // Randomized presses against the model until the board fills, plus a few more.
        do_reset();
        m_turn  = 1'b1;
        m_count = 0;
        m_over  = 1'b0;
        extra   = 0;
        for (int p = 0; p < 400 && extra < 4; p++) begin
            if ($urandom_range(0, 9) == 0) v.key0 = oor[$urandom_range(0, 4)];
            else                           v.key0 = 8'h1E + 8'($urandom_range(0, 6));
            v.key1 = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            v.hold = $urandom_range(1, 4);
            v.rel  = $urandom_range(2, 3);
            v.cf   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            model_press(v.key0, v.cf, er, eb, einv);
            v.exp_red   = er;
            v.exp_black = eb;
            v.exp_inv   = einv;
            v.exp_turn  = m_turn;
            v.exp_count = 6'(m_count);
            apply_press(v);
            if (m_over) extra++;
        end
        check("random run board_full", board_full, 1'b1);
        check("random run move_count", move_count, 6'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/connect_move_ctrl.md
CONNECT_MOVE_CTRL -- requirements
Module: connect_move_ctrl

Interface
REQ-001 Parameter NUM_COLS, default 7: number of board columns.
REQ-002 Parameter NUM_ROWS, default 6: pieces per column; board capacity is NUM_COLS*NUM_ROWS.
REQ-003 Parameter KEY_BASE, default 8'h1E: keycode of column 0; column c maps to KEY_BASE+c.
REQ-004 Clock and reset SHALL be one clock and an asynchronous active-low reset, named as follows.
REQ-005 frame_clk  input  1  the only clock, rising edge.
REQ-006 Reset_n  input  1  asynchronous active-low reset.
REQ-007 keycode  input  8  current keyboard keycode, level, 8'h00 = no key.
REQ-008 col_full  input  NUM_COLS  bit c = 1 when column c holds NUM_ROWS pieces, from the column stages.
REQ-009 game_over  input  1  level from the win detector; 1 = a player has won.
REQ-010 drop_red  output  NUM_COLS  one-hot, one-cycle pulse: place a red piece in column c.
REQ-011 drop_black  output  NUM_COLS  one-hot, one-cycle pulse: place a black piece in column c.
REQ-012 turn_red  output  1  1 = red to move, 0 = black to move.
REQ-013 invalid_move  output  1  one-cycle pulse: key press rejected because the column is full.
REQ-014 move_count  output  6  number of accepted moves since reset.
REQ-015 board_full  output  1  level; 1 when move_count equals NUM_COLS*NUM_ROWS.

Function
REQ-016 All outputs SHALL be registered; drop_red and drop_black SHALL never both be nonzero, and each SHALL have at most one bit set.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_REL and OVER.
REQ-018 IDLE with keycode==0: stay in IDLE.
REQ-019 IDLE with keycode in KEY_BASE..KEY_BASE+NUM_COLS-1 and col_full[c]==0: latch c and go to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle.
- Drive bit c of drop_red if turn_red=1, else bit c of drop_black.
- Toggle turn_red and increment move_count on the same edge.
- Go to WAIT_REL.
REQ-021 Latency: key valid at edge N -> drop pulse high for the cycle after edge N+1.
REQ-022 IDLE with a valid column key and col_full[c]==1:
- Pulse invalid_move for one cycle.
- Go to WAIT_REL; turn_red and move_count unchanged.
REQ-023 IDLE with a nonzero keycode outside the column range: no output; go to WAIT_REL.
REQ-024 WAIT_REL SHALL stay until keycode==0, then go to IDLE; a held key SHALL produce exactly one move or one invalid_move.
REQ-025 A key change from one nonzero code to another without passing through 8'h00 SHALL be ignored.
REQ-026 game_over==1 in any state SHALL force OVER on the next edge.
- In IDLE, game_over has priority over a simultaneous valid key: no drop, no count change.
- An ISSUE pulse already registered completes normally.
REQ-027 When move_count reaches NUM_COLS*NUM_ROWS (42):
- board_full SHALL assert on the same edge.
- The FSM SHALL enter OVER instead of WAIT_REL.
REQ-028 OVER SHALL hold all pulses at 0 and hold turn_red and move_count; it is exited only by reset.
REQ-029 move_count SHALL saturate at NUM_COLS*NUM_ROWS and never wrap.

Reset
REQ-030 Reset_n==0 SHALL immediately (asynchronously) set:
- state=IDLE
- drop_red=0, drop_black=0, invalid_move=0
- turn_red=1, move_count=0, board_full=0
REQ-031 A reset asserted during ISSUE SHALL clear the pulse in the same cycle; no partial move is counted.
REQ-032 After Reset_n deasserts with a key held, the block SHALL treat the key as a new press in IDLE.

Verification
REQ-033 Reset, then keycode 8'h22 for 5 cycles, then 8'h00: drop_red=7'b0010000 for exactly one cycle, two edges after the key; turn_red=0; move_count=1.
REQ-034 Alternating presses 8'h1E, 8'h1E with release between: drop_red[0] pulse, then drop_black[0] pulse; turn_red returns to 1; move_count=2.
REQ-035 col_full=7'b0000100 with keycode 8'h20: invalid_move pulses once; no drop; turn_red and move_count unchanged.
REQ-036 game_over=1 on the same edge as keycode 8'h24 in IDLE: no drop; state OVER; later presses produce no output.
REQ-037 42 valid alternating moves: board_full=1, move_count=42; a 43rd press produces no drop.
REQ-038 Reset_n=0 mid-ISSUE: drop outputs fall to 0 without a clock edge; move_count=0; turn_red=1.
